// File: rtl/n_piso_shift_reg.sv
// N-bit parallel-in, serial-out shift register.
// Valid/ready word load, MSB- or LSB-first serial output, gapless reload.
module n_piso_shift_reg #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] load_data,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         dir,
  input  logic         shift_en,
  output logic         d_out,
  output logic         out_valid,
  output logic         done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   shreg, shreg_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           dir_q, dir_n;
  logic           done_q, done_n;

  logic last;
  logic step;
  logic accept;

  assign last = (state == SHIFT)
             && shift_en
             && (cnt == LAST);
  assign step = (state == SHIFT)
             && shift_en
             && !last;

  assign load_ready = !reset
                   && ((state == IDLE) || last);
  assign accept = load_valid && load_ready;

  assign out_valid = (state == SHIFT);
  assign done = done_q;

  always_comb begin
    d_out = 1'b0;
    if (out_valid)
      d_out = dir_q ? shreg[0] : shreg[N-1];
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    dir_n   = dir_q;
    done_n  = last;
    // accept and step are exclusive: accept in SHIFT implies last
    unique case (1'b1)
      accept: begin
        shreg_n = load_data;
        dir_n   = dir;
        cnt_n   = '0;
        state_n = SHIFT;
      end
      last && !accept: begin
        shreg_n = '0;
        cnt_n   = '0;
        state_n = IDLE;
      end
      step: begin
        if (dir_q)
          shreg_n = {1'b0, shreg[N-1:1]};
        else
          shreg_n = {shreg[N-2:0], 1'b0};
        cnt_n = cnt + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      cnt    <= cnt_n;
      dir_q  <= dir_n;
      done_q <= done_n;
    end
  end

endmodule
